// File: rtl/imm_ext_if.sv
// Stream bundle for the immediate-extension stage: upstream offer side and
// downstream execute side, each with a valid/ready handshake.
interface imm_ext_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_instr;
   logic [DATA_W-1:0] in_pc;
   logic [2:0]        in_sel;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [DATA_W-1:0] out_pc;
   logic [DATA_W-1:0] out_imm;
   logic              out_err;

   modport slave (
      input  in_valid, in_instr, in_pc, in_sel, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_imm, out_err
   );

   modport master (
      output in_valid, in_instr, in_pc, in_sel, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_imm, out_err
   );
endinterface

// File: rtl/imm_ext_stage.sv
// Decode-to-execute immediate generation with a two-entry skid buffer,
// pipeline flush and a saturating illegal-select counter.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no entry held, out_valid low
// S_ONE   | main register holds an entry
// S_FULL  | main and skid both hold entries, in_ready low
module imm_ext_stage #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   imm_ext_if.slave         bus,
   output logic [CNT_W-1:0] err_count
);
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] imm;
      logic              err;
   } entry_t;

   state_t            state_q, state_nxt;
   entry_t            main_q, skid_q, in_entry;
   logic              in_ready_q;
   logic              out_valid_w;
   logic              accept, retire;
   logic              load_main, load_skid, skid_to_main;
   logic [DATA_W-1:0] ext_imm;
   logic              ext_err;

   // An entry offered during a flush is dropped, so it never counts as accepted.
   assign accept = bus.in_valid && in_ready_q && !flush;
   assign retire = out_valid_w && bus.out_ready;

   // Immediate extension from the select code, ahead of the registers.
   always_comb begin
      ext_imm = '0;
      ext_err = 1'b0;
      case (bus.in_sel)
         3'b000:  ext_imm = {{(DATA_W-5){1'b0}}, bus.in_instr[4:0]};
         3'b001:  ext_imm = {{(DATA_W-8){1'b0}}, bus.in_instr[7:0]};
         3'b010:  ext_imm = {{(DATA_W-5){bus.in_instr[4]}}, bus.in_instr[4:0]};
         3'b100:  ext_imm = {{(DATA_W-8){bus.in_instr[7]}}, bus.in_instr[7:0]};
         3'b110:  ext_imm = {{(DATA_W-11){bus.in_instr[10]}}, bus.in_instr[10:0]};
         default: ext_err = 1'b1;
      endcase
   end

   assign in_entry = '{instr: bus.in_instr, pc: bus.in_pc, imm: ext_imm, err: ext_err};

   // State register; in_ready is decoded from the next state so it leaves a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_nxt;
         in_ready_q <= (state_nxt != S_FULL);
      end
   end

   // Next-state decode; flush overrides the handshake outcome.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_EMPTY: if (accept) state_nxt = S_ONE;
         S_ONE: begin
            if (accept && !retire)      state_nxt = S_FULL;
            else if (retire && !accept) state_nxt = S_EMPTY;
         end
         S_FULL:  if (retire) state_nxt = S_ONE;
         default: state_nxt = S_EMPTY;
      endcase
      if (flush) state_nxt = S_EMPTY;
   end

   // Output and datapath-steering decode of the current state.
   always_comb begin
      out_valid_w  = (state_q != S_EMPTY);
      load_main    = ((state_q == S_EMPTY) && accept) ||
                     ((state_q == S_ONE) && accept && retire);
      load_skid    = (state_q == S_ONE) && accept && !retire;
      skid_to_main = (state_q == S_FULL) && retire;
   end

   // Entry storage: main drives the outputs, skid catches one extra entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main)         main_q <= in_entry;
         else if (skid_to_main) main_q <= skid_q;
         if (load_skid)         skid_q <= in_entry;
      end
   end

   // Illegal-select counter, saturating, survives flush.
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (accept && ext_err && (err_count != {CNT_W{1'b1}}))
         err_count <= err_count + CNT_W'(1);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_w;
   assign bus.out_instr = main_q.instr;
   assign bus.out_pc    = main_q.pc;
   assign bus.out_imm   = main_q.imm;
   assign bus.out_err   = main_q.err;
endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: scoreboard of expected entries filled on accept,
// drained and compared on retire, plus per-scenario directed checks.
module tb_imm_ext_stage;
   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] imm;
      logic        err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [7:0] err_count;
   int         checks = 0;
   int         errors = 0;
   exp_t       sb[$];
   int         exp_cnt = 0;

   imm_ext_if #(.DATA_W(16)) bus ();

   imm_ext_stage #(.DATA_W(16), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] model(input logic [15:0] i, input logic [2:0] s);
      case (s)
         3'd0:    return {1'b0, 11'b0, i[4:0]};
         3'd1:    return {1'b0, 8'b0, i[7:0]};
         3'd2:    return {1'b0, {11{i[4]}}, i[4:0]};
         3'd4:    return {1'b0, {8{i[7]}}, i[7:0]};
         3'd6:    return {1'b0, {5{i[10]}}, i[10:0]};
         default: return {1'b1, 16'b0};
      endcase
   endfunction

   // Scoreboard monitor: inputs are stable between negedge and the next posedge.
   always @(negedge clk) begin
      exp_t       e;
      logic [16:0] m;
      if (rst) begin
         sb.delete();
         exp_cnt = 0;
      end else begin
         checks++;
         if (err_count !== exp_cnt[7:0]) begin
            errors++;
            $display("FAIL err_count_track got %0d want %0d", err_count, exp_cnt);
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out got instr %h want nothing", bus.out_instr);
            end else begin
               e = sb.pop_front();
               if ({bus.out_instr, bus.out_pc, bus.out_imm, bus.out_err} !== e) begin
                  errors++;
                  $display("FAIL retire_entry got %h/%h/%h/%b want %h/%h/%h/%b",
                           bus.out_instr, bus.out_pc, bus.out_imm, bus.out_err,
                           e.instr, e.pc, e.imm, e.err);
               end
            end
         end
         if (flush) sb.delete();
         else if (bus.in_valid && bus.in_ready) begin
            m = model(bus.in_instr, bus.in_sel);
            sb.push_back('{instr: bus.in_instr, pc: bus.in_pc, imm: m[15:0], err: m[16]});
            if (m[16] && exp_cnt != 255) exp_cnt++;
         end
      end
   end

   // Present an entry and return just after the edge that accepts it; valid stays up.
   task automatic offer(input logic [15:0] i, input logic [15:0] p, input logic [2:0] s);
      int   n;
      logic acc;
      bus.in_valid = 1'b1;
      bus.in_instr = i;
      bus.in_pc    = p;
      bus.in_sel   = s;
      n = 0;
      acc = 1'b0;
      while (!acc) begin
         @(negedge clk);
         acc = bus.in_ready && !flush && !rst;
         @(posedge clk);
         #1;
         n++;
         if (!acc && n > 50) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout got no accept want accept within 50 cycles");
            acc = 1'b1;
         end
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.in_sel = '0;
      bus.out_ready = 1'b0;
      do_reset();
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_err} !== 3'b010) begin
         errors++;
         $display("FAIL reset_handshake got v/r/e %b%b%b want 010",
                  bus.out_valid, bus.in_ready, bus.out_err);
      end
      checks++;
      if ({bus.out_instr, bus.out_pc, bus.out_imm, err_count} !== 56'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h %0d want zeros",
                  bus.out_instr, bus.out_pc, bus.out_imm, err_count);
      end
      cycles(3);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle got v/r %b%b want 01", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_select;
      logic [15:0] vi[6] = '{16'h0015, 16'h0015, 16'h0480, 16'h0480, 16'h0400, 16'h1234};
      logic [2:0]  vs[6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b110, 3'b101};
      logic [15:0] vx[6] = '{16'hFFF5, 16'h0015, 16'hFF80, 16'h0080, 16'hFC00, 16'h0000};
      logic        ve[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      bus.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         offer(vi[k], 16'h0100 + 16'(k), vs[k]);
         bus.in_valid = 1'b0;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_imm !== vx[k] || bus.out_err !== ve[k]) begin
            errors++;
            $display("FAIL select_%0d got v=%b imm=%h err=%b want v=1 imm=%h err=%b",
                     k, bus.out_valid, bus.out_imm, bus.out_err, vx[k], ve[k]);
         end
         cycles(1);
      end
      checks++;
      if (err_count !== 8'd1) begin
         errors++;
         $display("FAIL select_err_count got %0d want 1", err_count);
      end
   endtask

   task automatic test_backpressure;
      bus.out_ready = 1'b0;
      offer(16'hA00A, 16'h0A0A, 3'b000);
      offer(16'hB00B, 16'h0B0B, 3'b001);
      bus.in_instr = 16'hC00C; bus.in_pc = 16'h0C0C; bus.in_sel = 3'b010;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_instr !== 16'hA00A || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_%0d got r=%b v=%b instr=%h want r=0 v=1 instr=a00a",
                     k, bus.in_ready, bus.out_valid, bus.out_instr);
         end
         cycles(1);
      end
      bus.out_ready = 1'b1;
      cycles(1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'hB00B || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_drain_b got v=%b instr=%h r=%b want v=1 instr=b00b r=1",
                  bus.out_valid, bus.out_instr, bus.in_ready);
      end
      cycles(1);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'hC00C) begin
         errors++;
         $display("FAIL bp_drain_c got v=%b instr=%h want v=1 instr=c00c",
                  bus.out_valid, bus.out_instr);
      end
      cycles(1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty got v=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] i;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         i = 16'($urandom);
         offer(i, 16'h2000 + 16'(k), 3'($urandom_range(0, 7)));
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== i) begin
            errors++;
            $display("FAIL stream_%0d got v=%b instr=%h want v=1 instr=%h",
                     k, bus.out_valid, bus.out_instr, i);
         end
      end
      bus.in_valid = 1'b0;
      cycles(2);
      checks++;
      if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain got pending=%0d v=%b want 0 0", sb.size(), bus.out_valid);
      end
   endtask

   task automatic test_flush;
      logic [7:0] c;
      bus.out_ready = 1'b0;
      offer(16'h1111, 16'h0001, 3'b000);
      offer(16'h2222, 16'h0002, 3'b001);
      bus.in_instr = 16'hDEAD; bus.in_pc = 16'h0003; bus.in_sel = 3'b111;
      flush = 1'b1;
      c = err_count;
      cycles(1);
      flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || err_count !== c) begin
         errors++;
         $display("FAIL flush_full got v=%b r=%b cnt=%0d want v=0 r=1 cnt=%0d",
                  bus.out_valid, bus.in_ready, err_count, c);
      end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycles(1);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped_%0d got v=%b instr=%h want v=0",
                     k, bus.out_valid, bus.out_instr);
         end
      end
   endtask

   task automatic test_saturation;
      do_reset();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 260; k++) offer(16'(k), 16'(k), 3'b011);
      bus.in_valid = 1'b0;
      cycles(2);
      checks++;
      if (err_count !== 8'd255) begin
         errors++;
         $display("FAIL sat_count got %0d want 255", err_count);
      end
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      cycles(1);
      checks++;
      if (err_count !== 8'd255) begin
         errors++;
         $display("FAIL sat_after_flush got %0d want 255", err_count);
      end
      bus.out_ready = 1'b0;
      offer(16'h3333, 16'h0033, 3'b000);
      offer(16'h4444, 16'h0044, 3'b110);
      bus.in_valid = 1'b0;
      do_reset();
      checks++;
      if (err_count !== 8'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.out_instr !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid got cnt=%0d v=%b r=%b instr=%h want 0 0 1 0000",
                  err_count, bus.out_valid, bus.in_ready, bus.out_instr);
      end
   endtask

   initial begin
      test_reset();
      test_select();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
